// File: rtl/armdashcam_intc_pkg.sv
// Shared constants, types and helpers for the armdashcam interrupt controller.
package armdashcam_intc_pkg;

    localparam int MAX_IRQS    = 64;
    localparam int DEF_PRIO_W  = 3;

    typedef logic [DEF_PRIO_W-1:0] prio_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/armdashcam_intc_prio_tree.sv
// Combinational max-finder over {prio, ~idx}: highest priority wins, ties go to lowest index.
module armdashcam_intc_prio_tree
    import armdashcam_intc_pkg::*;
#(
    parameter int N      = 8,
    parameter int PRIO_W = DEF_PRIO_W,
    parameter int ID_W   = clog2(N)
) (
    input  logic [N-1:0]        i_req,
    input  logic [N*PRIO_W-1:0] i_prio,
    output logic                o_valid,
    output logic [ID_W-1:0]     o_id,
    output logic [PRIO_W-1:0]   o_prio
);

    localparam int P = 1 << ID_W;

    logic [P-1:0]                  w_req_pad;
    logic [P*PRIO_W-1:0]           w_prio_pad;
    logic [2*P-1:0]                w_v;
    logic [2*P-1:0][PRIO_W-1:0]    w_p;
    logic [2*P-1:0][ID_W-1:0]      w_id;

    assign w_req_pad  = P'(i_req);
    assign w_prio_pad = (P*PRIO_W)'(i_prio);

    // Heap layout: leaves at P..2P-1, root at 1; left child always holds the lower index.
    always_comb begin
        w_v  = '0;
        w_p  = '0;
        w_id = '0;
        for (int i = 0; i < P; i++) begin
            w_v[P+i]  = w_req_pad[i];
            w_p[P+i]  = w_prio_pad[i*PRIO_W +: PRIO_W];
            w_id[P+i] = ID_W'(i);
        end
        for (int n = P - 1; n >= 1; n--) begin
            if (w_v[2*n] && (!w_v[2*n+1] || (w_p[2*n] >= w_p[2*n+1]))) begin
                w_v[n]  = w_v[2*n];
                w_p[n]  = w_p[2*n];
                w_id[n] = w_id[2*n];
            end else begin
                w_v[n]  = w_v[2*n+1];
                w_p[n]  = w_p[2*n+1];
                w_id[n] = w_id[2*n+1];
            end
        end
        o_valid = w_v[1];
        o_id    = w_v[1] ? w_id[1] : '0;
        o_prio  = w_v[1] ? w_p[1]  : '0;
    end

endmodule

// File: rtl/armdashcam_intc.sv
// Prioritised interrupt controller with claim/EOI handshake and priority nesting.
module armdashcam_intc
    import armdashcam_intc_pkg::*;
#(
    parameter  int NUM_IRQS = 8,
    parameter  int PRIO_W   = DEF_PRIO_W,
    localparam int ID_W     = clog2(NUM_IRQS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_IRQS-1:0] irq_src,
    input  logic                cfg_wr,
    input  logic [ID_W-1:0]     cfg_idx,
    input  logic                cfg_en,
    input  logic                cfg_edge,
    input  logic [PRIO_W-1:0]   cfg_prio,
    output logic                irq_valid,
    output logic [ID_W-1:0]     irq_id,
    output logic [PRIO_W-1:0]   irq_prio,
    input  logic                irq_ready,
    input  logic                eoi_valid,
    input  logic [ID_W-1:0]     eoi_id,
    output logic [NUM_IRQS-1:0] in_service
);

    localparam logic [ID_W:0] NUM_L = (ID_W+1)'(NUM_IRQS);

    logic [NUM_IRQS-1:0]        r_en, r_edge, r_pend, r_insvc, r_src_d;
    logic [NUM_IRQS*PRIO_W-1:0] r_prio_cfg;
    logic                       r_valid;
    logic [ID_W-1:0]            r_id;
    logic [PRIO_W-1:0]          r_prio;

    logic                       w_claim, w_cfg_ok, w_eoi_ok;
    logic [NUM_IRQS-1:0]        w_claim_vec, w_cfg_vec, w_eoi_vec, w_eoi_eff;
    logic [NUM_IRQS-1:0]        w_rise, w_edge_dis, w_pend_n, w_elig;
    logic                       w_thr_valid, w_win_valid, w_cur_elig;
    logic [ID_W-1:0]            w_thr_id, w_win_id;
    logic [PRIO_W-1:0]          w_thr, w_win_prio;

    assign w_claim  = r_valid & irq_ready;
    assign w_cfg_ok = cfg_wr & ({1'b0, cfg_idx} < NUM_L);
    assign w_eoi_ok = eoi_valid & ({1'b0, eoi_id} < NUM_L);

    assign w_claim_vec = w_claim  ? (NUM_IRQS'(1) << r_id)    : '0;
    assign w_cfg_vec   = w_cfg_ok ? (NUM_IRQS'(1) << cfg_idx) : '0;
    assign w_eoi_vec   = w_eoi_ok ? (NUM_IRQS'(1) << eoi_id)  : '0;
    // An EOI that collides with a claim of the same id loses.
    assign w_eoi_eff   = w_eoi_vec & r_insvc & ~w_claim_vec;

    assign w_rise     = irq_src & ~r_src_d;
    assign w_edge_dis = w_cfg_vec & {NUM_IRQS{~cfg_en}} & r_edge;
    assign w_pend_n   = (~r_edge & irq_src)
                      | (r_edge & ~w_edge_dis & (w_rise | (r_pend & ~w_claim_vec)));

    armdashcam_intc_prio_tree #(.N(NUM_IRQS), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_thr_tree (
        .i_req   (r_insvc),
        .i_prio  (r_prio_cfg),
        .o_valid (w_thr_valid),
        .o_id    (w_thr_id),
        .o_prio  (w_thr)
    );

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            w_elig[i] = r_pend[i] & r_en[i] & ~r_insvc[i]
                      & (r_prio_cfg[i*PRIO_W +: PRIO_W] > w_thr);
        end
    end

    armdashcam_intc_prio_tree #(.N(NUM_IRQS), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_arb_tree (
        .i_req   (w_elig),
        .i_prio  (r_prio_cfg),
        .o_valid (w_win_valid),
        .o_id    (w_win_id),
        .o_prio  (w_win_prio)
    );

    assign w_cur_elig = w_elig[r_id];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_en       <= '0;
            r_edge     <= '0;
            r_prio_cfg <= '0;
            r_pend     <= '0;
            r_insvc    <= '0;
            r_src_d    <= '0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_prio     <= '0;
        end else begin
            r_en    <= (r_en   & ~w_cfg_vec) | (w_cfg_vec & {NUM_IRQS{cfg_en}});
            r_edge  <= (r_edge & ~w_cfg_vec) | (w_cfg_vec & {NUM_IRQS{cfg_edge}});
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (w_cfg_vec[i]) r_prio_cfg[i*PRIO_W +: PRIO_W] <= cfg_prio;
            end
            r_src_d <= irq_src;
            r_pend  <= w_pend_n;
            r_insvc <= (r_insvc | w_claim_vec) & ~w_eoi_eff;

            // Claim forces a one-cycle bubble; a shown winner is only displaced by a
            // strictly higher priority or by losing its own eligibility.
            if (w_claim) begin
                r_valid <= 1'b0;
            end else if (!(r_valid && w_cur_elig && !(w_win_valid && (w_win_prio > r_prio)))) begin
                r_valid <= w_win_valid;
                r_id    <= w_win_id;
                r_prio  <= w_win_prio;
            end
        end
    end

    assign irq_valid  = r_valid;
    assign irq_id     = r_id;
    assign irq_prio   = r_prio;
    assign in_service = r_insvc;

endmodule

// File: tb/tb_armdashcam_intc.sv
// Directed bench for armdashcam_intc: reset, latency, arbitration, nesting, edge/level, config corners.
module tb_armdashcam_intc;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_src;
    logic       cfg_wr, cfg_en, cfg_edge;
    logic [2:0] cfg_idx, cfg_prio;
    logic       irq_valid, irq_ready, eoi_valid;
    logic [2:0] irq_id, irq_prio, eoi_id;
    logic [7:0] in_service;

    logic [4:0] b_src;
    logic       b_cfg_wr, b_cfg_en, b_cfg_edge;
    logic [2:0] b_cfg_idx, b_cfg_prio;
    logic       b_valid, b_ready, b_eoi_valid;
    logic [2:0] b_id, b_prio, b_eoi_id;
    logic [4:0] b_insvc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    armdashcam_intc #(.NUM_IRQS(8), .PRIO_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .irq_src(irq_src),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_edge(cfg_edge), .cfg_prio(cfg_prio),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_prio(irq_prio), .irq_ready(irq_ready),
        .eoi_valid(eoi_valid), .eoi_id(eoi_id), .in_service(in_service)
    );

    armdashcam_intc #(.NUM_IRQS(5), .PRIO_W(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .irq_src(b_src),
        .cfg_wr(b_cfg_wr), .cfg_idx(b_cfg_idx), .cfg_en(b_cfg_en), .cfg_edge(b_cfg_edge), .cfg_prio(b_cfg_prio),
        .irq_valid(b_valid), .irq_id(b_id), .irq_prio(b_prio), .irq_ready(b_ready),
        .eoi_valid(b_eoi_valid), .eoi_id(b_eoi_id), .in_service(b_insvc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int idx, input bit en, input bit ed, input int prio);
        cfg_wr   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_en   = en;
        cfg_edge = ed;
        cfg_prio = 3'(prio);
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic eoi(input int id);
        eoi_valid = 1'b1;
        eoi_id    = 3'(id);
        tick();
        eoi_valid = 1'b0;
    endtask

    task automatic claim();
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input bit v, input int id, input int prio);
        chk({tag, "_valid"}, 64'(irq_valid), 64'(v));
        chk({tag, "_id"},    64'(irq_id),    64'(id));
        chk({tag, "_prio"},  64'(irq_prio),  64'(prio));
    endtask

    initial begin
        reset_n = 1'b0; irq_src = 8'hFF;
        cfg_wr = 0; cfg_idx = 0; cfg_en = 0; cfg_edge = 0; cfg_prio = 0;
        irq_ready = 0; eoi_valid = 0; eoi_id = 0;
        b_src = 5'h1F; b_cfg_wr = 0; b_cfg_idx = 0; b_cfg_en = 0; b_cfg_edge = 0; b_cfg_prio = 0;
        b_ready = 0; b_eoi_valid = 0; b_eoi_id = 0;

        // 1 reset with all sources high
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_valid", 64'(irq_valid), 0);
            chk("rst_insvc", 64'(in_service), 0);
        end
        chk_irq("rst", 0, 0, 0);
        irq_src = 8'h00;
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_valid", 64'(irq_valid), 0);

        // 2 latency
        cfg(3, 1, 1, 5);
        irq_src[3] = 1'b1;
        tick();
        chk("lat_t1_valid", 64'(irq_valid), 0);
        tick();
        chk_irq("lat_t2", 1, 3, 5);
        claim();
        chk("lat_claim_insvc", 64'(in_service), 64'h08);
        chk("lat_bubble", 64'(irq_valid), 0);
        irq_src[3] = 1'b0;
        eoi(3);
        chk("lat_eoi_insvc", 64'(in_service), 0);
        tick();
        chk("lat_edge_cleared", 64'(irq_valid), 0);

        // 3 priority and tie-break
        cfg(1, 1, 1, 2);
        cfg(4, 1, 1, 6);
        cfg(6, 1, 1, 6);
        irq_src = 8'b0101_0010;
        tick(); tick();
        chk_irq("tie", 1, 4, 6);
        claim();
        chk("tie_claim_insvc", 64'(in_service), 64'h10);
        tick();
        chk("thr_block", 64'(irq_valid), 0);
        eoi(4);
        chk("tie_eoi_insvc", 64'(in_service), 0);
        tick();
        chk_irq("tie_next", 1, 6, 6);
        claim();
        chk("tie6_insvc", 64'(in_service), 64'h40);
        tick();
        chk("low_blocked", 64'(irq_valid), 0);
        eoi(6);
        tick();
        chk_irq("low_after", 1, 1, 2);
        claim();
        chk("src1_insvc", 64'(in_service), 64'h02);
        eoi(1);
        chk("src1_eoi", 64'(in_service), 0);
        irq_src = 8'h00;
        tick();

        // 4 nesting
        cfg(2, 1, 1, 3);
        cfg(5, 1, 1, 7);
        cfg(0, 1, 1, 3);
        irq_src[2] = 1'b1;
        tick(); tick();
        chk_irq("nest_base", 1, 2, 3);
        claim();
        chk("nest_insvc1", 64'(in_service), 64'h04);
        irq_src[5] = 1'b1;
        tick();
        chk("nest_t1", 64'(irq_valid), 0);
        tick();
        chk_irq("nest_preempt", 1, 5, 7);
        claim();
        chk("nest_insvc2", 64'(in_service), 64'h24);
        irq_src[0] = 1'b1;
        tick(); tick();
        chk("nest_hold", 64'(irq_valid), 0);
        eoi(5);
        chk("nest_eoi5", 64'(in_service), 64'h04);
        tick();
        chk("nest_equal_blocked", 64'(irq_valid), 0);
        eoi(2);
        chk("nest_eoi2", 64'(in_service), 0);
        tick();
        chk_irq("nest_src0", 1, 0, 3);
        claim();
        eoi(0);
        chk("nest_clean", 64'(in_service), 0);
        irq_src = 8'h00;
        tick();

        // 4b shown winner held against an equal-priority lower index
        irq_src[6] = 1'b1;
        tick(); tick();
        chk_irq("hold_first", 1, 6, 6);
        irq_src[4] = 1'b1;
        tick(); tick();
        chk_irq("hold_equal", 1, 6, 6);
        claim();
        eoi(6);
        tick();
        chk_irq("hold_after", 1, 4, 6);
        claim();
        eoi(4);
        irq_src = 8'h00;
        tick();

        // 5 level withdraw, edge re-arm in claim cycle
        cfg(7, 1, 0, 4);
        irq_src[7] = 1'b1;
        tick(); tick();
        chk_irq("lvl_up", 1, 7, 4);
        irq_src[7] = 1'b0;
        tick(); tick();
        chk("lvl_withdraw", 64'(irq_valid), 0);
        chk("lvl_insvc", 64'(in_service), 0);
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        tick();
        chk_irq("reedge_first", 1, 1, 2);
        irq_src[1] = 1'b1;
        claim();
        chk("reedge_insvc", 64'(in_service), 64'h02);
        chk("reedge_bubble", 64'(irq_valid), 0);
        tick();
        chk("reedge_masked", 64'(irq_valid), 0);
        eoi(1);
        tick();
        chk_irq("reedge_replay", 1, 1, 2);
        claim();
        irq_src = 8'h00;
        eoi(1);
        tick();

        // 6 config corners
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        cfg(3, 0, 1, 5);
        tick();
        cfg(3, 1, 1, 5);
        tick(); tick();
        chk("dis_clr", 64'(irq_valid), 0);
        irq_src[4] = 1'b1;
        tick(); tick();
        chk_irq("idle_eoi_pre", 1, 4, 6);
        claim();
        eoi(6);
        chk("idle_eoi", 64'(in_service), 64'h10);
        eoi(4);
        chk("idle_eoi_clean", 64'(in_service), 0);
        irq_src = 8'h00;

        // out-of-range index on a 5-source instance
        b_cfg_wr = 1'b1; b_cfg_idx = 3'd7; b_cfg_en = 1'b1; b_cfg_edge = 1'b0; b_cfg_prio = 3'd7;
        tick();
        b_cfg_wr = 1'b0;
        tick(); tick();
        chk("oor_cfg_valid", 64'(b_valid), 0);
        b_cfg_wr = 1'b1; b_cfg_idx = 3'd2; b_cfg_prio = 3'd1;
        tick();
        b_cfg_wr = 1'b0;
        tick();
        chk("inr_cfg_valid", 64'(b_valid), 1);
        chk("inr_cfg_id", 64'(b_id), 2);
        chk("inr_cfg_prio", 64'(b_prio), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
